// File: rtl/xnor_cmp_arbiter.sv
// xnor_cmp_arbiter: round-robin shared bit-serial XNOR word comparator
module xnor_cmp_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         cmp_bit,
  output logic         done,
  output logic         eq,
  output logic         owner
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [W-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic eq_acc, prio, sel, x;
  assign x = ~(sa[0] ^ sb[0]);
  assign busy = state != IDLE;
  assign cmp_bit = (state == SHIFT) & x;
  assign sel = (req0 & req1) ? prio : req1;
  // arbitrate in IDLE, shift one bit per cycle in SHIFT, publish result in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      eq_acc <= 1'b1;
      prio   <= 1'b0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done   <= 1'b0;
      eq     <= 1'b0;
      owner  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req0 | req1) begin
          sa     <= sel ? a1 : a0;
          sb     <= sel ? b1 : b0;
          gnt0   <= ~sel;
          gnt1   <= sel;
          cnt    <= '0;
          eq_acc <= 1'b1;
          prio   <= ~sel;
          state  <= SHIFT;
        end
        SHIFT: begin
          eq_acc <= eq_acc & x;
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          cnt    <= (cnt == LAST) ? cnt : cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            done  <= 1'b1;
            eq    <= eq_acc & x;
            owner <= gnt1;
          end
        end
        default: begin
          done  <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
